// File: rtl/controle_pista_pkg.sv
// Shared types and constants for the track controller.
// State encoding, digit geometry and the default track.
package controle_pista_pkg;

  localparam int DIGITO_W  = 4;
  localparam int N_DIGITOS = 6;
  localparam int PISTA_W   = DIGITO_W * N_DIGITOS;
  localparam int CNT_W     = 3;

  localparam logic [PISTA_W-1:0] PISTA_PADRAO_DEF = 24'h590060;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    PROGRAMA  = 3'd1,
    ENVIA     = 3'd2,
    AGUARDA   = 3'd3,
    EXECUTA   = 3'd4,
    BLOQUEIO  = 3'd5,
    CONCLUIDO = 3'd6
  } estado_t;

  // Shift one digit into a track word from the LSB side.
  function automatic logic [PISTA_W-1:0] desloca(
    input logic [PISTA_W-1:0]  r,
    input logic [DIGITO_W-1:0] d
  );
    return {r[PISTA_W-DIGITO_W-1:0], d};
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for the operator insert level.
// One pulse per press no matter how long it is held.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulso
);

  logic d_ant;

  // Previous sample of the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_ant <= 1'b0;
    else        d_ant <= d;
  end

  assign pulso = d & ~d_ant;

endmodule

// File: rtl/controle_pista.sv
// Operator-facing controller: track programming, run
// sequencing, retry counting and timed lockout.
module controle_pista
  import controle_pista_pkg::*;
#(
  parameter int MAX_TENTATIVAS = 3,
  parameter int TEMPO_BLOQUEIO = 16,
  parameter logic [PISTA_W-1:0] PISTA_PADRAO = PISTA_PADRAO_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGITO_W-1:0] numero,
  input  logic                insere,
  input  logic                programa,
  input  logic                erro_in,
  output logic [PISTA_W-1:0]  pista,
  output logic [DIGITO_W-1:0] numero_out,
  output logic                insere_pulso,
  output logic                reset_pista,
  output logic [1:0]          tentativas,
  output logic                bloqueado,
  output logic                concluido,
  output logic                ocupado
);

  localparam int BW =
    (TEMPO_BLOQUEIO > 1) ? $clog2(TEMPO_BLOQUEIO) : 1;
  localparam logic [BW-1:0] BLOQ_INI =
    BW'(TEMPO_BLOQUEIO - 1);
  localparam logic [1:0] MAX_T = 2'(MAX_TENTATIVAS);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_DIGITOS - 1);
  localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(N_DIGITOS);

  logic evento;

  estado_t             estado, estado_nx;
  logic [PISTA_W-1:0]  shadow, shadow_nx;
  logic [PISTA_W-1:0]  pista_nx;
  logic [CNT_W-1:0]    cnt_prog, cnt_prog_nx;
  logic [CNT_W-1:0]    cnt_run, cnt_run_nx;
  logic [BW-1:0]       cnt_bloq, cnt_bloq_nx;
  logic [1:0]          tent_nx;
  logic [DIGITO_W-1:0] num_nx;
  logic                pulso_nx;
  logic                rpista_nx;

  detector_borda u_borda (
    .clk   (clk),
    .reset (reset),
    .d     (insere),
    .pulso (evento)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    estado_nx   = estado;
    shadow_nx   = shadow;
    pista_nx    = pista;
    cnt_prog_nx = cnt_prog;
    cnt_run_nx  = cnt_run;
    cnt_bloq_nx = cnt_bloq;
    tent_nx     = tentativas;
    num_nx      = numero_out;
    pulso_nx    = 1'b0;
    rpista_nx   = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (programa) begin
          estado_nx = PROGRAMA;
        end else if (evento) begin
          estado_nx = ENVIA;
          pulso_nx  = 1'b1;
          num_nx    = numero;
        end
      end
      PROGRAMA: begin
        if (!programa) begin
          estado_nx   = OCIOSO;
          cnt_prog_nx = '0;
          shadow_nx   = '0;
        end else if (evento) begin
          shadow_nx = desloca(shadow, numero);
          if (cnt_prog == ULTIMO) begin
            pista_nx    = desloca(shadow, numero);
            cnt_prog_nx = '0;
            estado_nx   = OCIOSO;
            rpista_nx   = 1'b1;
          end else begin
            cnt_prog_nx = cnt_prog + 1'b1;
          end
        end
      end
      ENVIA: begin
        estado_nx = AGUARDA;
      end
      AGUARDA: begin
        if (erro_in) begin
          if (tentativas != MAX_T) tent_nx = tentativas + 1'b1;
          cnt_run_nx = '0;
          rpista_nx  = 1'b1;
          if (tent_nx == MAX_T) begin
            estado_nx   = BLOQUEIO;
            cnt_bloq_nx = BLOQ_INI;
          end else begin
            estado_nx = OCIOSO;
          end
        end else begin
          cnt_run_nx = cnt_run + 1'b1;
          if (cnt_run_nx == TOTAL) estado_nx = CONCLUIDO;
          else                     estado_nx = EXECUTA;
        end
      end
      EXECUTA: begin
        if (evento) begin
          estado_nx = ENVIA;
          pulso_nx  = 1'b1;
          num_nx    = numero;
        end
      end
      BLOQUEIO: begin
        if (cnt_bloq == '0) begin
          estado_nx = OCIOSO;
          tent_nx   = '0;
          rpista_nx = 1'b1;
        end else begin
          cnt_bloq_nx = cnt_bloq - 1'b1;
        end
      end
      CONCLUIDO: begin
        if (programa) begin
          estado_nx  = PROGRAMA;
          tent_nx    = '0;
          cnt_run_nx = '0;
          rpista_nx  = 1'b1;
        end
      end
      default: begin
        estado_nx = OCIOSO;
      end
    endcase
  end

  // State and output registers; flags follow the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      pista        <= PISTA_PADRAO;
      shadow       <= '0;
      cnt_prog     <= '0;
      cnt_run      <= '0;
      cnt_bloq     <= '0;
      tentativas   <= '0;
      numero_out   <= '0;
      insere_pulso <= 1'b0;
      reset_pista  <= 1'b0;
      bloqueado    <= 1'b0;
      concluido    <= 1'b0;
      ocupado      <= 1'b0;
    end else begin
      estado       <= estado_nx;
      pista        <= pista_nx;
      shadow       <= shadow_nx;
      cnt_prog     <= cnt_prog_nx;
      cnt_run      <= cnt_run_nx;
      cnt_bloq     <= cnt_bloq_nx;
      tentativas   <= tent_nx;
      numero_out   <= num_nx;
      insere_pulso <= pulso_nx;
      reset_pista  <= rpista_nx;
      bloqueado    <= (estado_nx == BLOQUEIO);
      concluido    <= (estado_nx == CONCLUIDO);
      ocupado      <= (estado_nx != OCIOSO);
    end
  end

endmodule

// File: tb/tb_controle_pista.sv
// Self-checking bench for controle_pista.
// Directed scenarios plus a randomized run against a model.
`timescale 1ns/1ps
module tb_controle_pista;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  numero = '0;
  logic        insere = 1'b0;
  logic        programa = 1'b0;
  logic        erro_in = 1'b0;
  logic [23:0] pista;
  logic [3:0]  numero_out;
  logic        insere_pulso, reset_pista;
  logic [1:0]  tentativas;
  logic        bloqueado, concluido, ocupado;

  int checks = 0;
  int failures = 0;

  // model of the operator-visible behaviour
  logic [23:0] m_pista;
  logic [1:0]  m_tent;
  int          m_run;
  bit          m_done;

  controle_pista dut (
    .clk          (clk),
    .reset        (reset),
    .numero       (numero),
    .insere       (insere),
    .programa     (programa),
    .erro_in      (erro_in),
    .pista        (pista),
    .numero_out   (numero_out),
    .insere_pulso (insere_pulso),
    .reset_pista  (reset_pista),
    .tentativas   (tentativas),
    .bloqueado    (bloqueado),
    .concluido    (concluido),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  // the two strobes must never coincide
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (insere_pulso && reset_pista) begin
        failures++;
        $display("FAIL strobe_overlap: got both high want exclusive");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 0; insere = 0; programa = 0; erro_in = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    m_pista = 24'h590060; m_tent = 0; m_run = 0; m_done = 0;
  endtask

  // one operator press spanning the 3-cycle minimum spacing
  task automatic press(input logic [3:0] d, input logic e,
                       output logic p0, output int np,
                       output logic [3:0] no, output int nrp);
    np = 0; nrp = 0;
    @(negedge clk);
    numero = d; insere = 1; erro_in = e;
    @(posedge clk); #1;
    p0 = insere_pulso; no = numero_out;
    if (insere_pulso) np++;
    if (reset_pista) nrp++;
    @(negedge clk);
    insere = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (insere_pulso) np++;
      if (reset_pista) nrp++;
    end
    erro_in = 0;
  endtask

  task automatic program_digits(input logic [23:0] v,
                                output int rpc, output int np);
    logic p0; int n, r; logic [3:0] no;
    rpc = 0; np = 0;
    @(negedge clk);
    programa = 1;
    @(posedge clk); #1;
    if (reset_pista) rpc++;
    if (insere_pulso) np++;
    for (int i = 5; i >= 0; i--) begin
      press(v[i*4 +: 4], 1'b0, p0, n, no, r);
      rpc += r; np += n;
    end
    @(negedge clk);
    programa = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (reset_pista) rpc++;
      if (insere_pulso) np++;
    end
  endtask

  // called one cycle into lockout; returns its length
  task automatic wait_lock(output int cyc, output int np);
    cyc = 1; np = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      insere = (i < 10) ? (i % 2 == 1) : 1'b0;
      @(posedge clk); #1;
      if (insere_pulso) np++;
      if (!bloqueado) break;
      cyc++;
    end
    insere = 0;
  endtask

  task automatic test_reset();
    int np;
    @(negedge clk);
    reset = 0; #1;
    checks++;
    if (pista !== 24'h590060) begin
      failures++;
      $display("FAIL reset_pista_val: got %h want 590060", pista);
    end
    checks++;
    if ({numero_out, insere_pulso, reset_pista, tentativas,
         bloqueado, concluido, ocupado} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0",
               {numero_out, insere_pulso, reset_pista, tentativas,
                bloqueado, concluido, ocupado});
    end
    @(negedge clk);
    reset = 1;
    np = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (insere_pulso || reset_pista || ocupado) np++;
    end
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL reset_release_quiet: got %0d want 0", np);
    end
  endtask

  task automatic test_run();
    logic [3:0] dig [6];
    logic p0; int np, nrp; logic [3:0] no;
    dig = '{4'd5, 4'd9, 4'd0, 4'd0, 4'd6, 4'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(dig[i], 1'b0, p0, np, no, nrp);
      checks++;
      if (p0 !== 1'b1 || np != 1) begin
        failures++;
        $display("FAIL run_pulse%0d: got p0=%b n=%0d want 1/1",
                 i, p0, np);
      end
      checks++;
      if (no !== dig[i]) begin
        failures++;
        $display("FAIL run_digit%0d: got %h want %h", i, no, dig[i]);
      end
      checks++;
      if (concluido !== (i == 5)) begin
        failures++;
        $display("FAIL run_done%0d: got %b want %b",
                 i, concluido, (i == 5));
      end
    end
    press(4'd3, 1'b0, p0, np, no, nrp);
    checks++;
    if (np != 0 || concluido !== 1'b1) begin
      failures++;
      $display("FAIL done_ignores: got n=%0d c=%b want 0/1",
               np, concluido);
    end
  endtask

  task automatic test_hold();
    int np;
    do_reset();
    np = 0;
    @(negedge clk);
    numero = 4'd7; insere = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (insere_pulso) np++;
    end
    @(negedge clk);
    insere = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (insere_pulso) np++;
    end
    checks++;
    if (np != 1) begin
      failures++;
      $display("FAIL hold_one_pulse: got %0d want 1", np);
    end
    checks++;
    if (numero_out !== 4'd7) begin
      failures++;
      $display("FAIL hold_digit: got %h want 7", numero_out);
    end
  endtask

  task automatic test_lockout();
    logic p0; int np, nrp, cyc, g; logic [3:0] no;
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      g = $urandom_range(0, 4);
      for (int k = 0; k < g; k++)
        press(4'($urandom_range(0, 15)), 1'b0, p0, np, no, nrp);
      press(4'($urandom_range(0, 15)), 1'b1, p0, np, no, nrp);
      checks++;
      if (nrp != 1 || tentativas !== 2'(r)) begin
        failures++;
        $display("FAIL err_run%0d: got rp=%0d t=%0d want 1/%0d",
                 r, nrp, tentativas, r);
      end
      checks++;
      if (bloqueado !== (r == 3)) begin
        failures++;
        $display("FAIL lock_flag%0d: got %b want %b",
                 r, bloqueado, (r == 3));
      end
    end
    wait_lock(cyc, np);
    checks++;
    if (cyc != 16) begin
      failures++;
      $display("FAIL lock_len: got %0d want 16", cyc);
    end
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL lock_ignores: got %0d want 0", np);
    end
    checks++;
    if (reset_pista !== 1'b1 || tentativas !== 2'd0 ||
        ocupado !== 1'b0) begin
      failures++;
      $display("FAIL lock_exit: got rp=%b t=%0d o=%b want 1/0/0",
               reset_pista, tentativas, ocupado);
    end
  endtask

  task automatic test_program();
    logic p0; int np, nrp, rpc, npp; logic [3:0] no;
    logic [23:0] v;
    do_reset();
    program_digits(24'h123456, rpc, npp);
    checks++;
    if (pista !== 24'h123456 || rpc != 1 || npp != 0) begin
      failures++;
      $display("FAIL prog_commit: got %h rp=%0d p=%0d want 123456/1/0",
               pista, rpc, npp);
    end
    rpc = 0;
    @(negedge clk);
    programa = 1;
    for (int i = 7; i <= 9; i++) begin
      press(4'(i), 1'b0, p0, np, no, nrp);
      rpc += nrp;
    end
    @(negedge clk);
    programa = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (reset_pista) rpc++;
    end
    checks++;
    if (pista !== 24'h123456 || rpc != 0 || ocupado !== 1'b0) begin
      failures++;
      $display("FAIL prog_abort: got %h rp=%0d o=%b want 123456/0/0",
               pista, rpc, ocupado);
    end
    v = 24'($urandom);
    program_digits(v, rpc, npp);
    checks++;
    if (pista !== v || rpc != 1) begin
      failures++;
      $display("FAIL prog_after_abort: got %h rp=%0d want %h/1",
               pista, rpc, v);
    end
  endtask

  task automatic test_reset_mid();
    logic p0; int np, nrp; logic [3:0] no;
    do_reset();
    for (int i = 0; i < 3; i++)
      press(4'($urandom_range(0, 15)), 1'b0, p0, np, no, nrp);
    @(negedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if (pista !== 24'h590060 ||
        {numero_out, insere_pulso, reset_pista, tentativas,
         bloqueado, concluido, ocupado} !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset: got %h %b want 590060/0", pista,
               {numero_out, insere_pulso, reset_pista, tentativas,
                bloqueado, concluido, ocupado});
    end
    @(negedge clk);
    reset = 1;
    np = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (insere_pulso || reset_pista) np++;
    end
    checks++;
    if (np != 0) begin
      failures++;
      $display("FAIL mid_release: got %0d want 0", np);
    end
    for (int i = 0; i < 3; i++)
      press(4'($urandom_range(0, 15)), 1'b0, p0, np, no, nrp);
    checks++;
    if (concluido !== 1'b0) begin
      failures++;
      $display("FAIL mid_progress_lost: got %b want 0", concluido);
    end
  endtask

  task automatic test_priority();
    logic p0; int np, nrp; logic [3:0] no;
    logic [23:0] v;
    do_reset();
    @(negedge clk);
    programa = 1; insere = 1; numero = 4'd4;
    @(posedge clk); #1;
    checks++;
    if (insere_pulso !== 1'b0 || ocupado !== 1'b1) begin
      failures++;
      $display("FAIL prio_enter: got p=%b o=%b want 0/1",
               insere_pulso, ocupado);
    end
    @(negedge clk);
    insere = 0;
    v = 24'hA1B2C3;
    for (int i = 5; i >= 0; i--)
      press(v[i*4 +: 4], 1'b0, p0, np, no, nrp);
    checks++;
    if (pista !== v) begin
      failures++;
      $display("FAIL prio_no_shift: got %h want %h", pista, v);
    end
    @(negedge clk);
    programa = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic p0; int np, nrp, rpc, cyc; logic [3:0] no, d;
    logic e; logic [23:0] v;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      if (m_done) begin
        if ($urandom_range(0, 1) == 1) begin
          do_reset();
          checks++;
          if (pista !== m_pista) begin
            failures++;
            $display("FAIL rnd_reset: got %h want %h", pista, m_pista);
          end
        end else begin
          v = 24'($urandom);
          program_digits(v, rpc, np);
          m_pista = v; m_tent = 0; m_run = 0; m_done = 0;
          checks++;
          if (pista !== m_pista || rpc != 2 || np != 0 ||
              tentativas !== m_tent) begin
            failures++;
            $display("FAIL rnd_reprog: got %h rp=%0d t=%0d want %h/2/0",
                     pista, rpc, tentativas, m_pista);
          end
        end
      end else if (m_run == 0 && $urandom_range(0, 7) == 0) begin
        v = 24'($urandom);
        program_digits(v, rpc, np);
        m_pista = v;
        checks++;
        if (pista !== m_pista || rpc != 1 || tentativas !== m_tent) begin
          failures++;
          $display("FAIL rnd_prog: got %h rp=%0d t=%0d want %h/1/%0d",
                   pista, rpc, tentativas, m_pista, m_tent);
        end
      end else begin
        d = 4'($urandom_range(0, 15));
        e = ($urandom_range(0, 4) == 0);
        press(d, e, p0, np, no, nrp);
        if (e) begin
          if (m_tent != 2'd3) m_tent++;
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == 6) m_done = 1;
        end
        checks++;
        if (p0 !== 1'b1 || np != 1 || no !== d ||
            nrp != int'(e)) begin
          failures++;
          $display("FAIL rnd_press%0d: got p=%b n=%0d d=%h rp=%0d want 1/1/%h/%0d",
                   it, p0, np, no, nrp, d, e);
        end
        checks++;
        if (tentativas !== m_tent || concluido !== m_done ||
            bloqueado !== (m_tent == 2'd3)) begin
          failures++;
          $display("FAIL rnd_state%0d: got t=%0d c=%b b=%b want %0d/%b/%b",
                   it, tentativas, concluido, bloqueado,
                   m_tent, m_done, (m_tent == 2'd3));
        end
        if (m_tent == 2'd3) begin
          wait_lock(cyc, np);
          m_tent = 0;
          checks++;
          if (cyc != 16 || np != 0 || tentativas !== m_tent) begin
            failures++;
            $display("FAIL rnd_lock%0d: got len=%0d p=%0d t=%0d want 16/0/0",
                     it, cyc, np, tentativas);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_hold();
    test_lockout();
    test_program();
    test_reset_mid();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
